// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, and hazard stall/flush. Flushed or emptied slots always carry
// ctrl=0 so they read as bubbles downstream.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_EMPTY | no beat held, occupancy 0
//  ST_ONE   | head holds one beat, occupancy 1
//  ST_TWO   | head and skid both hold beats, occupancy 2
//           | (reachable only when SKID_EN=1)
module pipe_stage_buf #(
    parameter int DATA_W         = 160,
    parameter int CTRL_W         = 24,
    parameter int SKID_EN        = 1,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              beat_in;
    logic              beat_out;

    // Handshake qualifiers. With the skid enabled o_ready has no path from
    // i_ready, which breaks the combinational ready chain between stages.
    always_comb begin
        o_valid = (state != ST_EMPTY) & ~i_stall;
        if (SKID_EN != 0) begin
            o_ready = (state != ST_TWO) & ~i_stall;
        end else begin
            o_ready = ((state == ST_EMPTY) | i_ready) & ~i_stall;
        end
        beat_in  = i_valid & o_ready;
        beat_out = o_valid & i_ready;
    end

    assign o_data      = main_data;
    assign o_ctrl      = main_ctrl;
    assign o_occupancy = state;

    // Occupancy FSM and storage. Flush beats stall and any handshake; a
    // vacated slot has its ctrl cleared while its payload is left stale.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (i_flush) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (FLUSH_CLR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else if (!i_stall) begin
            case (state)
                ST_EMPTY: begin
                    if (beat_in) begin
                        state     <= ST_ONE;
                        main_data <= i_data;
                        main_ctrl <= i_ctrl;
                    end
                end
                ST_ONE: begin
                    if (beat_in && beat_out) begin
                        main_data <= i_data;
                        main_ctrl <= i_ctrl;
                    end else if (beat_in && (SKID_EN != 0)) begin
                        state     <= ST_TWO;
                        skid_data <= i_data;
                        skid_ctrl <= i_ctrl;
                    end else if (beat_out) begin
                        state     <= ST_EMPTY;
                        main_ctrl <= '0;
                    end
                end
                ST_TWO: begin
                    if (beat_out) begin
                        state     <= ST_ONE;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_ctrl <= '0;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
